// File: rtl/ysyx_22041412_decode_pipe_if.sv
// Bus between fetch, the decode stage and execute.
// The slave modport is the decode stage. The master modport is its environment:
// it drives the instruction, flush and out_ready, and it observes the decoded bundle.
interface ysyx_22041412_decode_pipe_if #(
    parameter int XLEN = 64
) ();
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic            func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imme;
    logic            v1_pc;
    logic            v2_imm;
    logic            mul_en;
    logic            illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, func3, func7,
               rs1, rs2, rd, imme, v1_pc, v2_imm, mul_en, illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, func3, func7,
               rs1, rs2, rd, imme, v1_pc, v2_imm, mul_en, illegal
    );
endinterface

// File: rtl/ysyx_22041412_decode_pipe.sv
// Registered RV32/RV64 instruction decode stage.
// Each instruction is decoded as it is captured and held in a two-entry skid buffer.
// The outputs always show the main entry (M). The skid entry (S) absorbs one
// instruction while downstream stalls. Because of S, in_ready is derived from
// registered state only and never from out_ready.
module ysyx_22041412_decode_pipe #(
    parameter int XLEN  = 64,
    parameter bit M_EXT = 1'b1
) (
    input logic clk,
    input logic rst,
    ysyx_22041412_decode_pipe_if.slave bus
);
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_OP32    = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic            func7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imme;
        logic            v1_pc;
        logic            v2_imm;
        logic            mul_en;
        logic            illegal;
    } bundle_t;

    // Buffer occupancy: ONE means only M holds an instruction; FULL means M and S both do.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    bundle_t            r_m;
    bundle_t            r_s;
    bundle_t            w_dec;
    logic [31:0]        w_ins;
    logic signed [63:0] w_imm;
    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_ld_m_in;
    logic               w_ld_m_s;
    logic               w_ld_s;

    assign w_ins      = bus.in_instr;
    assign w_in_ready = (r_state != ST_FULL) & ~bus.flush;
    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = (r_state != ST_EMPTY) & bus.out_ready;

    // Combinational decode of the presented instruction.
    // The immediate is built at 64 bits and then truncated, so that RV32 gets the same sign extension.
    always_comb begin
        w_imm          = '0;
        w_dec          = '0;
        w_dec.pc       = bus.in_pc;
        w_dec.opcode   = w_ins[6:0];
        w_dec.func3    = w_ins[14:12];
        w_dec.func7    = w_ins[30];
        w_dec.rs1      = w_ins[19:15];
        w_dec.rs2      = w_ins[24:20];
        w_dec.rd       = w_ins[11:7];
        case (w_ins[6:0])
            OP_LUI, OP_AUIPC: begin
                w_imm        = {{32{w_ins[31]}}, w_ins[31:12], 12'b0};
                w_dec.v1_pc  = 1'b1;
                w_dec.v2_imm = 1'b1;
            end
            OP_JAL: begin
                w_imm = {{44{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_OPIMM: begin
                w_imm        = {{52{w_ins[31]}}, w_ins[31:20]};
                w_dec.v2_imm = 1'b1;
            end
            OP_OPIMM32: begin
                w_imm         = {{52{w_ins[31]}}, w_ins[31:20]};
                w_dec.v2_imm  = 1'b1;
                w_dec.illegal = (XLEN == 32);
            end
            OP_SYSTEM: begin
                w_imm = {{52{w_ins[31]}}, w_ins[31:20]};
            end
            OP_STORE: begin
                w_imm        = {{52{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
                w_dec.v2_imm = 1'b1;
            end
            OP_BRANCH: begin
                w_imm = {{52{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            end
            OP_OP: begin
                w_dec.illegal = 1'b0;
            end
            OP_OP32: begin
                w_dec.illegal = (XLEN == 32);
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
        w_dec.mul_en = M_EXT & ((w_ins[6:0] == OP_OP) | (w_ins[6:0] == OP_OP32))
                       & (w_ins[31:25] == 7'b0000001);
        w_dec.imme   = w_imm[XLEN-1:0];
    end

    // Occupancy register; an asynchronous reset discards both entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next occupancy and entry load strobes. A flush empties the buffer after any output fire in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_m_in   = 1'b0;
        w_ld_m_s    = 1'b0;
        w_ld_s      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_ONE;
                    w_ld_m_in   = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_out_fire && w_in_fire) begin
                    w_ld_m_in = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_in_fire) begin
                    w_state_nxt = ST_FULL;
                    w_ld_s      = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt = ST_ONE;
                    w_ld_m_s    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Entry payloads. Reset clears them so that every output reads zero while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m <= '0;
            r_s <= '0;
        end else begin
            if (w_ld_m_in) begin
                r_m <= w_dec;
            end else if (w_ld_m_s) begin
                r_m <= r_s;
            end
            if (w_ld_s) begin
                r_s <= w_dec;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign bus.out_pc    = r_m.pc;
    assign bus.opcode    = r_m.opcode;
    assign bus.func3     = r_m.func3;
    assign bus.func7     = r_m.func7;
    assign bus.rs1       = r_m.rs1;
    assign bus.rs2       = r_m.rs2;
    assign bus.rd        = r_m.rd;
    assign bus.imme      = r_m.imme;
    assign bus.v1_pc     = r_m.v1_pc;
    assign bus.v2_imm    = r_m.v2_imm;
    assign bus.mul_en    = r_m.mul_en;
    assign bus.illegal   = r_m.illegal;
endmodule

// File: tb/tb_ysyx_22041412_decode_pipe.sv
// Bench for the decode stage. It runs three configurations in lockstep:
// RV64 with M, RV32 with M, and RV64 without M.
// A queue of captured (instr, pc) pairs models the buffer, and the expected
// decoded fields are computed arithmetically from the instruction encoding rules.
module tb_ysyx_22041412_decode_pipe;
    typedef struct packed {
        logic        vld;
        logic        rdy;
        logic [63:0] pc;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        v1;
        logic        v2;
        logic        mul;
        logic        ill;
    } obs_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [63:0] pc;
    } item_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] imm;
        logic        v1;
        logic        v2;
        logic        mul;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        t_flush;
    logic        t_vld;
    logic        t_ordy;
    logic [31:0] t_ins;
    logic [63:0] t_pc;
    int          total;
    int          bad;
    item_t       q[$];
    obs_t        o_a;
    obs_t        o_b;
    obs_t        o_c;

    ysyx_22041412_decode_pipe_if #(.XLEN(64)) if_a ();
    ysyx_22041412_decode_pipe_if #(.XLEN(32)) if_b ();
    ysyx_22041412_decode_pipe_if #(.XLEN(64)) if_c ();

    ysyx_22041412_decode_pipe #(.XLEN(64), .M_EXT(1'b1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    ysyx_22041412_decode_pipe #(.XLEN(32), .M_EXT(1'b1)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    ysyx_22041412_decode_pipe #(.XLEN(64), .M_EXT(1'b0)) u_c (.clk(clk), .rst(rst), .bus(if_c));

    assign if_a.flush = t_flush;  assign if_b.flush = t_flush;  assign if_c.flush = t_flush;
    assign if_a.in_valid = t_vld; assign if_b.in_valid = t_vld; assign if_c.in_valid = t_vld;
    assign if_a.out_ready = t_ordy; assign if_b.out_ready = t_ordy; assign if_c.out_ready = t_ordy;
    assign if_a.in_instr = t_ins; assign if_b.in_instr = t_ins; assign if_c.in_instr = t_ins;
    assign if_a.in_pc = t_pc;     assign if_b.in_pc = t_pc[31:0]; assign if_c.in_pc = t_pc;

    assign o_a = {if_a.out_valid, if_a.in_ready, if_a.out_pc, if_a.opcode, if_a.func3, if_a.func7,
                  if_a.rs1, if_a.rs2, if_a.rd, if_a.imme, if_a.v1_pc, if_a.v2_imm, if_a.mul_en, if_a.illegal};
    assign o_b = {if_b.out_valid, if_b.in_ready, 32'b0, if_b.out_pc, if_b.opcode, if_b.func3, if_b.func7,
                  if_b.rs1, if_b.rs2, if_b.rd, 32'b0, if_b.imme, if_b.v1_pc, if_b.v2_imm, if_b.mul_en, if_b.illegal};
    assign o_c = {if_c.out_valid, if_c.in_ready, if_c.out_pc, if_c.opcode, if_c.func3, if_c.func7,
                  if_c.rs1, if_c.rs2, if_c.rd, if_c.imme, if_c.v1_pc, if_c.v2_imm, if_c.mul_en, if_c.illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Expected decode computed from the encoding rules with integer arithmetic.
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] pc, input int xl, input bit mx);
        exp_t   e;
        int     s;
        longint sg;
        longint imm;
        bit     known;
        logic [6:0] op;
        s     = ins;
        sg    = ins[31] ? -64'sd1 : 64'sd0;
        op    = ins[6:0];
        imm   = 0;
        known = 1'b1;
        e     = '0;
        case (op)
            7'h37, 7'h17: begin imm = longint'(s) & ~64'sd4095; e.v1 = 1'b1; e.v2 = 1'b1; end
            7'h6F: imm = sg * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                         + longint'(ins[30:21]) * 2;
            7'h67, 7'h03, 7'h13, 7'h1B: begin imm = longint'(s >>> 20); e.v2 = 1'b1; end
            7'h73: imm = longint'(s >>> 20);
            7'h23: begin imm = longint'(s >>> 25) * 32 + longint'(ins[11:7]); e.v2 = 1'b1; end
            7'h63: imm = sg * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                         + longint'(ins[11:8]) * 2;
            7'h33, 7'h3B: imm = 0;
            default: known = 1'b0;
        endcase
        e.ill = !known || (xl == 32 && (op == 7'h1B || op == 7'h3B));
        e.mul = mx && (op == 7'h33 || op == 7'h3B) && (ins[31:25] == 7'b0000001);
        e.imm = imm;
        e.pc  = pc;
        if (xl == 32) begin
            e.imm = e.imm & 64'hFFFF_FFFF;
            e.pc  = e.pc & 64'hFFFF_FFFF;
        end
        return e;
    endfunction

    task automatic cmp(input string nm, input obs_t o, input int xl, input bit mx, input bit fl);
        exp_t  e;
        item_t h;
        chk({nm, ".in_ready"}, 64'(o.rdy), 64'(q.size() < 2 && !fl));
        if (q.size() == 0) begin
            chk({nm, ".out_valid"}, 64'(o.vld), 64'd0);
        end else begin
            h = q[0];
            e = ref_dec(h.ins, h.pc, xl, mx);
            chk({nm, ".out_valid"}, 64'(o.vld), 64'd1);
            chk({nm, ".out_pc"}, o.pc, e.pc);
            chk({nm, ".opcode"}, 64'(o.opc), 64'(h.ins[6:0]));
            chk({nm, ".func3"}, 64'(o.f3), 64'(h.ins[14:12]));
            chk({nm, ".func7"}, 64'(o.f7), 64'(h.ins[30]));
            chk({nm, ".rs1"}, 64'(o.rs1), 64'(h.ins[19:15]));
            chk({nm, ".rs2"}, 64'(o.rs2), 64'(h.ins[24:20]));
            chk({nm, ".rd"}, 64'(o.rd), 64'(h.ins[11:7]));
            chk({nm, ".imme"}, o.imm, e.imm);
            chk({nm, ".v1_pc"}, 64'(o.v1), 64'(e.v1));
            chk({nm, ".v2_imm"}, 64'(o.v2), 64'(e.v2));
            chk({nm, ".mul_en"}, 64'(o.mul), 64'(e.mul));
            chk({nm, ".illegal"}, 64'(o.ill), 64'(e.ill));
        end
    endtask

    // One clock cycle: drive the inputs, check all three DUTs against the model, then advance the model at the edge.
    task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc, input bit ordy, input bit fl);
        bit    fin;
        bit    fout;
        item_t it;
        t_vld   = v;
        t_ins   = ins;
        t_pc    = pc;
        t_ordy  = ordy;
        t_flush = fl;
        #1;
        cmp("a64", o_a, 64, 1'b1, fl);
        cmp("b32", o_b, 32, 1'b1, fl);
        cmp("c64nm", o_c, 64, 1'b0, fl);
        fin  = v && (q.size() < 2) && !fl;
        fout = (q.size() > 0) && ordy;
        it.ins = ins;
        it.pc  = pc;
        @(posedge clk);
        if (fout) void'(q.pop_front());
        if (fl) q.delete();
        else if (fin) q.push_back(it);
        @(negedge clk);
    endtask

    logic [6:0] ops [14];
    logic [31:0] r_ins;

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        t_flush = 1'b0;
        t_vld   = 1'b0;
        t_ordy  = 1'b0;
        t_ins   = '0;
        t_pc    = '0;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h1B, 7'h33, 7'h3B, 7'h73, 7'h00, 7'h7F};

        // reset state
        #2 rst = 1'b1;
        #1;
        chk("rst.a.out_valid", 64'(if_a.out_valid), 64'd0);
        chk("rst.a.out_pc", if_a.out_pc, 64'd0);
        chk("rst.a.imme", if_a.imme, 64'd0);
        chk("rst.a.opcode", 64'(if_a.opcode), 64'd0);
        chk("rst.a.illegal", 64'(if_a.illegal), 64'd0);
        chk("rst.b.out_valid", 64'(if_b.out_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.a.in_ready", 64'(if_a.in_ready), 64'd1);

        // directed decode, streaming with out_ready high
        step(1'b1, 32'hFFF10093, 64'h1000, 1'b1, 1'b0);
        chk("addi.out_valid", 64'(if_a.out_valid), 64'd1);
        chk("addi.opcode", 64'(if_a.opcode), 64'h13);
        chk("addi.rd", 64'(if_a.rd), 64'd1);
        chk("addi.rs1", 64'(if_a.rs1), 64'd2);
        chk("addi.imme", if_a.imme, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi.v2_imm", 64'(if_a.v2_imm), 64'd1);
        chk("addi.v1_pc", 64'(if_a.v1_pc), 64'd0);
        chk("addi.illegal", 64'(if_a.illegal), 64'd0);
        step(1'b1, 32'h025201B3, 64'h1004, 1'b1, 1'b0);
        chk("mul.a.mul_en", 64'(if_a.mul_en), 64'd1);
        chk("mul.a.rs1", 64'(if_a.rs1), 64'd4);
        chk("mul.a.rs2", 64'(if_a.rs2), 64'd5);
        chk("mul.a.rd", 64'(if_a.rd), 64'd3);
        chk("mul.a.imme", if_a.imme, 64'd0);
        chk("mul.a.v2_imm", 64'(if_a.v2_imm), 64'd0);
        chk("mul.c.mul_en", 64'(if_c.mul_en), 64'd0);
        step(1'b1, 32'h800002B7, 64'h1008, 1'b1, 1'b0);
        chk("lui.a.imme", if_a.imme, 64'hFFFF_FFFF_8000_0000);
        chk("lui.a.v1_pc", 64'(if_a.v1_pc), 64'd1);
        chk("lui.b.imme", 64'(if_b.imme), 64'h8000_0000);
        step(1'b1, 32'hFFDFF06F, 64'h100C, 1'b1, 1'b0);
        chk("jal.a.imme", if_a.imme, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("jal.b.imme", 64'(if_b.imme), 64'hFFFF_FFFC);
        step(1'b1, 32'h002081BB, 64'h1010, 1'b1, 1'b0);
        chk("op32.b.illegal", 64'(if_b.illegal), 64'd1);
        chk("op32.a.illegal", 64'(if_a.illegal), 64'd0);
        step(1'b1, 32'h00000000, 64'h1014, 1'b1, 1'b0);
        chk("zero.a.illegal", 64'(if_a.illegal), 64'd1);
        chk("zero.b.illegal", 64'(if_b.illegal), 64'd1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // backpressure: A in M, B in S, C held upstream
        step(1'b1, 32'h00100093, 64'hA0, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 64'hB0, 1'b0, 1'b0);
        chk("bp.full.in_ready", 64'(if_a.in_ready), 64'd0);
        chk("bp.full.out_pc", if_a.out_pc, 64'hA0);
        step(1'b1, 32'h00300193, 64'hC0, 1'b0, 1'b0);
        chk("bp.hold.out_pc", if_a.out_pc, 64'hA0);
        step(1'b1, 32'h00300193, 64'hC0, 1'b1, 1'b0);
        chk("bp.second.out_pc", if_a.out_pc, 64'hB0);
        step(1'b1, 32'h00300193, 64'hC0, 1'b1, 1'b0);
        chk("bp.third.out_pc", if_a.out_pc, 64'hC0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("bp.drained.out_valid", 64'(if_a.out_valid), 64'd0);

        // flush of a full buffer
        step(1'b1, 32'h00100093, 64'hD0, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 64'hD4, 1'b0, 1'b0);
        step(1'b1, 32'h00300193, 64'hD8, 1'b0, 1'b1);
        t_flush = 1'b0;
        t_vld   = 1'b0;
        #1;
        chk("flush.out_valid", 64'(if_a.out_valid), 64'd0);
        chk("flush.in_ready", 64'(if_a.in_ready), 64'd1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // asynchronous reset mid-stream
        step(1'b1, 32'h00100093, 64'hE0, 1'b0, 1'b0);
        chk("arst.before.out_valid", 64'(if_a.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst.a.out_valid", 64'(if_a.out_valid), 64'd0);
        chk("arst.b.out_valid", 64'(if_b.out_valid), 64'd0);
        chk("arst.a.out_pc", if_a.out_pc, 64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_ins = $urandom();
            r_ins[6:0] = ops[$urandom_range(0, 13)];
            if ($urandom_range(0, 3) == 0) r_ins[31:25] = 7'b0000001;
            step(($urandom_range(0, 3) != 0), r_ins, {$urandom(), $urandom()},
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_22041412_decode_pipe.md
# ysyx_22041412_decode_pipe

Registered, handshaked instruction decode stage parametrised for RV32/RV64 with an optional M-extension. It sits between the instruction fetch unit and the execute stage. Each instruction is decoded into register indices, a sign-extended immediate, operand-select flags and an illegal flag. Results are held in a two-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`.

## Interface
- `XLEN`, default 64: datapath width; legal values are 32 and 64; sets the `imme` and `pc` widths.
- `M_EXT`, default 1: when 0, `mul_en` is tied to 0.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous kill of all buffered instructions.
- `in_valid` input 1: upstream instruction valid.
- `in_ready` output 1: stage can accept.
- `in_instr` input 32: raw instruction.
- `in_pc` input XLEN: instruction PC.
- `out_valid` output 1: decoded bundle valid.
- `out_ready` input 1: downstream accepts.
- `out_pc` output XLEN: PC of the decoded instruction.
- `opcode` output 7: instr[6:0].
- `func3` output 3: instr[14:12].
- `func7` output 1: instr[30].
- `rs1` output 5: instr[19:15].
- `rs2` output 5: instr[24:20].
- `rd` output 5: instr[11:7].
- `imme` output XLEN: sign-extended immediate.
- `v1_pc` output 1: operand 1 selection; 1 = PC, 0 = rs1.
- `v2_imm` output 1: operand 2 selection; 1 = immediate, 0 = rs2.
- `mul_en` output 1: M-extension operation.
- `illegal` output 1: unsupported opcode.

## Operation
- Opcode classes:
  - LUI 0110111
  - AUIPC 0010111
  - JAL 1101111
  - JALR 1100111
  - BRANCH 1100011
  - LOAD 0000011
  - STORE 0100011
  - OPIMM 0010011
  - OPIMM32 0011011
  - OP 0110011
  - OP32 0111011
  - SYSTEM 1110011
- Immediates. All immediates are sign-extended from instr[31] to XLEN.
  - I-format (JALR, LOAD, OPIMM, OPIMM32, SYSTEM): instr[31:20].
  - S-format (STORE): {instr[31:25], instr[11:7]}.
  - B-format (BRANCH): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-format (LUI, AUIPC): {instr[31:12], 12'b0}.
  - J-format (JAL): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - OP, OP32 and illegal opcodes: imme = 0.
- `v1_pc` = 1 for LUI and AUIPC only.
- `v2_imm` = 1 for LOAD, STORE, OPIMM, OPIMM32, JALR, LUI and AUIPC; 0 otherwise.
- `mul_en` = M_EXT & (OP | OP32) & (instr[31:25] == 7'b0000001).
- `illegal` = 1 in either case below; all other fields are still passed through.
  - The opcode is not in the list above.
  - XLEN == 32 and the opcode is OPIMM32 or OP32.
- Skid buffer. Two entries, main (M) and skid (S), each holding a valid bit plus the full decoded bundle.
  - Outputs always drive M.
  - `in_ready` = ~S.valid & ~flush.
  - Input fires when in_valid & in_ready. Output fires when out_valid & out_ready.
- Buffer state machine, driven by the valid bits (empty / one / full):
  - Empty: an input fire loads M.
  - One: with output fire and input fire, M is reloaded from the input. With output fire only, M empties. With input fire only, the input goes to S (full).
  - Full: `in_ready` = 0. An output fire moves S into M and clears S.
- Order is strictly FIFO. The decoded bundle is computed combinationally from `in_instr` at capture time.
- `flush`: at the next edge, M.valid and S.valid go to 0. `in_ready` is 0 during the flush cycle, so any input presented in that cycle is dropped.

## Timing
- Latency: 1 cycle from input fire to `out_valid` when the buffer is empty.
- Throughput: 1 instruction per cycle while `out_ready` is held high.
- `in_ready` depends only on registered state and `flush`; there is no combinational path from `out_ready`.
- On reset, every output is 0: `out_valid`, all bundle fields, `out_pc`, `illegal`. `in_ready` is 1 once `rst` deasserts.
- Reset asserted mid-transfer discards both entries immediately (asynchronous).
- `flush` has priority over simultaneous input and output fires in the same cycle. The output fire is still counted by downstream; flush only removes the entries left after it.
- `out_valid` must stay high and the bundle stable until the output fires or a flush occurs.

## Test plan
- XLEN=64, `in_instr` 0xFFF10093 (addi x1,x2,-1):
  - Next cycle: `out_valid` = 1, `opcode` 0x13, `rd` 1, `rs1` 2, `imme` 0xFFFFFFFFFFFFFFFF, `v2_imm` 1, `v1_pc` 0, `illegal` 0.
- 0x025201B3 (mul x3,x4,x5):
  - M_EXT=1: `mul_en` 1, `rs1` 4, `rs2` 5, `rd` 3, `imme` 0, `v2_imm` 0.
  - M_EXT=0: `mul_en` 0.
- Immediate decode:
  - 0x800002B7 (lui x5,0x80000), XLEN=64: `imme` 0xFFFFFFFF80000000, `v1_pc` 1.
  - 0xFFDFF06F (jal x0,-4): `imme` all ones except bits[1:0] = 00 (−4).
- XLEN=32, opcode 0111011: `illegal` = 1. Opcode 0000000: `illegal` = 1 for both XLEN settings.
- Backpressure:
  - Hold `out_ready` = 0 and stream 3 instructions A, B, C: A sits in M, B in S, `in_ready` = 0, and C is held upstream.
  - Release `out_ready`: outputs appear in order A, B, C, one per cycle, with no loss or duplication.
- Flush and reset:
  - Buffer full, assert `flush` for one cycle: next cycle `out_valid` = 0 and `in_ready` = 1, and neither old entry reappears.
  - Assert `rst` mid-stream: `out_valid` drops without waiting for a clock edge.
